uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single system clock, all logic on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port i_user_tx_data, input, 8 bits: byte to send, transmitted LSB first; bits above the data width are ignored.
REQ-004 The block SHALL have port i_user_tx_valid, input, 1 bit: a byte is offered.
REQ-005 The block SHALL have port o_user_tx_ready, output, 1 bit: a byte can be accepted this cycle.
REQ-006 The block SHALL have port o_uart_tx, output, 1 bit: registered serial line, idle high.
REQ-007 The block SHALL have port i_uart_cts, input, 1 bit: clear-to-send, high = peer may receive.
REQ-008 The block SHALL have port o_tx_busy, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-009 The block SHALL have port i_div_num, input, 24 bits: clock cycles per bit; values 0 and 1 are treated as 2.
REQ-010 The block SHALL have port i_data_bit, input, 4 bits: data width, 5..8; values below 5 are treated as 5, above 8 as 8.
REQ-011 The block SHALL have port i_stop_bit, input, 2 bits: 2 selects two stop bits; 0, 1 and 3 select one.
REQ-012 The block SHALL have port i_check_bit, input, 2 bits: 0 = no parity, 1 = odd, 2 = even, 3 = no parity.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-014 o_user_tx_ready SHALL be high exactly when the state is IDLE and i_uart_cts = 1; it is combinational from the state and i_uart_cts.
REQ-015 A byte SHALL be accepted on a cycle where i_user_tx_valid and o_user_tx_ready are both 1.
REQ-016 On acceptance, the block SHALL latch the data, the clamped divisor, the width, the stop count and the parity mode; config changes mid-frame have no effect.
REQ-017 The transition IDLE->START SHALL occur on acceptance; o_uart_tx goes low on the next clock edge, so latency is 1 cycle.
REQ-018 Each bit (start, data, parity, stop) SHALL hold o_uart_tx for exactly the latched divisor cycles, timed by a down-counter reloaded at each bit boundary.
REQ-019 START SHALL go to DATA after one bit period.
REQ-020 DATA SHALL shift out the latched width bits LSB first, then go to PARITY if parity is enabled, else STOP.
REQ-021 The PARITY bit SHALL be the XOR of the sent data bits for even parity, and its inverse for odd parity.
REQ-022 STOP SHALL drive 1 for 1 or 2 bit periods, then go to IDLE.
REQ-023 Frame length SHALL be (1 + width + parity + stops) x divisor cycles, with no extra cycles between bits.
REQ-024 Back-to-back frames SHALL have exactly 1 idle-high cycle, the IDLE acceptance cycle, between the last stop bit and the next start bit.
REQ-025 A CTS drop mid-frame SHALL NOT abort the frame; it only blocks the next acceptance.
REQ-026 While i_uart_cts = 0 in IDLE, ready SHALL stay 0, the line stays high, and a held valid is accepted on the first cycle CTS = 1.
REQ-027 Valid without ready SHALL have no effect; data need not be held stable after acceptance.
REQ-028 o_tx_busy SHALL be 1 from the cycle after acceptance until the cycle the FSM re-enters IDLE.

Reset
REQ-029 Reset SHALL force IDLE, o_uart_tx = 1, o_tx_busy = 0, counters and shift register = 0, on the next clock edge.
REQ-030 o_user_tx_ready SHALL be 0 while reset is high.
REQ-031 A reset mid-frame SHALL abort the frame immediately; the line returns high on the next edge and no partial frame resumes.
REQ-032 After reset deasserts, the first acceptance SHALL be possible on the first cycle with valid = 1 and CTS = 1.

Verification
REQ-033 div=4, width 8, no parity, 1 stop, data 0xA5, CTS=1 -> line low 1 cycle after accept; then bits 1,0,1,0,0,1,0,1 each 4 cycles; then high; busy lasts 40 cycles.
REQ-034 div=3, width 8, even then odd parity, data 0xA5 -> parity bit 0 (even) and 1 (odd); frame 33 cycles.
REQ-035 div=2, width 5, 2 stops, data 0xFF -> 5 data ones; frame 16 cycles; bits 5-7 ignored.
REQ-036 div=0 -> bit period 2 cycles; width 12 -> 8 data bits.
REQ-037 Valid held with two bytes 0x12 and 0x34, div=4, 8N1 -> the second start bit begins exactly 1 cycle after the first frame's stop ends; CTS low during frame 1 -> frame 1 completes, frame 2 is held until CTS=1.
REQ-038 Reset asserted in DATA bit 3 -> next edge gives line=1, busy=0, ready=0 while reset is high; ready=1 the cycle after reset drops with CTS=1.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: valid/ready byte intake, runtime-configurable divisor,
// data width (5..8), parity and stop count, all latched per frame.
module uart_tx_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_user_tx_data,
    input  logic              i_user_tx_valid,
    output logic              o_user_tx_ready,
    output logic              o_uart_tx,
    input  logic              i_uart_cts,
    output logic              o_tx_busy,
    input  logic [DIV_W-1:0]  i_div_num,
    input  logic [3:0]        i_data_bit,
    input  logic [1:0]        i_stop_bit,
    input  logic [1:0]        i_check_bit
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [DATA_W-1:0]   r_shift;
    logic [3:0]          r_width;
    logic [3:0]          r_bit_idx;
    logic                r_two_stop;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_parity;
    logic                r_line;

    logic                w_ready;
    logic                w_accept;
    logic                w_bit_end;
    logic                w_last_data;
    logic                w_last_stop;
    logic                w_par_bit;
    logic [DIV_W-1:0]    w_div_clamped;
    logic [3:0]          w_width_clamped;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [3:0] clamp_width(input logic [3:0] w);
        if (w < 4'd5)
            return 4'd5;
        else if (w > 4'd8)
            return 4'd8;
        else
            return w;
    endfunction

    always_comb begin
        w_ready         = (r_state == IDLE) && i_uart_cts && !reset;
        w_accept        = w_ready && i_user_tx_valid;
        w_bit_end       = (r_cnt == '0);
        w_last_data     = (r_bit_idx == (r_width - 4'd1));
        w_last_stop     = (r_bit_idx == {3'b000, r_two_stop});
        // r_parity holds bits already sent; fold in the final data bit
        w_par_bit       = r_parity ^ r_shift[0] ^ r_par_odd;
        w_div_clamped   = clamp_div(i_div_num);
        w_width_clamped = clamp_width(i_data_bit);
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = START;
            START:   if (w_bit_end) w_state_nxt = DATA;
            DATA:    if (w_bit_end && w_last_data) w_state_nxt = r_par_en ? PARITY : STOP;
            PARITY:  if (w_bit_end) w_state_nxt = STOP;
            STOP:    if (w_bit_end && w_last_stop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_line     <= 1'b1;
            r_cnt      <= '0;
            r_div      <= '0;
            r_shift    <= '0;
            r_width    <= '0;
            r_bit_idx  <= '0;
            r_two_stop <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_parity   <= 1'b0;
        end else if (w_accept) begin
            r_line     <= 1'b0;
            r_cnt      <= w_div_clamped - DIV_W'(1);
            r_div      <= w_div_clamped;
            r_shift    <= i_user_tx_data;
            r_width    <= w_width_clamped;
            r_bit_idx  <= '0;
            r_two_stop <= (i_stop_bit == 2'd2);
            r_par_en   <= (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
            r_par_odd  <= (i_check_bit == 2'd1);
            r_parity   <= 1'b0;
        end else if (r_state != IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt - DIV_W'(1);
            end else begin
                r_cnt <= r_div - DIV_W'(1);
                case (r_state)
                    START: begin
                        r_line    <= r_shift[0];
                        r_bit_idx <= '0;
                    end
                    DATA: begin
                        r_parity <= r_parity ^ r_shift[0];
                        r_shift  <= r_shift >> 1;
                        if (!w_last_data) begin
                            r_line    <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end else begin
                            r_line    <= r_par_en ? w_par_bit : 1'b1;
                            r_bit_idx <= '0;
                        end
                    end
                    PARITY: begin
                        r_line    <= 1'b1;
                        r_bit_idx <= '0;
                    end
                    STOP: begin
                        r_line    <= 1'b1;
                        r_bit_idx <= w_last_stop ? 4'd0 : r_bit_idx + 4'd1;
                    end
                    default: r_line <= 1'b1;
                endcase
            end
        end
    end

    assign o_user_tx_ready = w_ready;
    assign o_uart_tx       = r_line;
    assign o_tx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, parity, clamping,
// back-to-back timing, CTS flow control and mid-frame reset.
module tb_uart_tx_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_user_tx_data;
    logic        i_user_tx_valid;
    logic        o_user_tx_ready;
    logic        o_uart_tx;
    logic        i_uart_cts;
    logic        o_tx_busy;
    logic [23:0] i_div_num;
    logic [3:0]  i_data_bit;
    logic [1:0]  i_stop_bit;
    logic [1:0]  i_check_bit;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    uart_tx_engine dut (
        .clock           (clock),
        .reset           (reset),
        .i_user_tx_data  (i_user_tx_data),
        .i_user_tx_valid (i_user_tx_valid),
        .o_user_tx_ready (o_user_tx_ready),
        .o_uart_tx       (o_uart_tx),
        .i_uart_cts      (i_uart_cts),
        .o_tx_busy       (o_tx_busy),
        .i_div_num       (i_div_num),
        .i_data_bit      (i_data_bit),
        .i_stop_bit      (i_stop_bit),
        .i_check_bit     (i_check_bit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic [23:0] div, input logic [3:0] width,
                           input logic [1:0] stop, input logic [1:0] par);
        i_div_num   = div;
        i_data_bit  = width;
        i_stop_bit  = stop;
        i_check_bit = par;
    endtask

    // Entered at the sample just after the acceptance edge; bits[i] is frame bit i.
    task automatic frame(input string name, input logic [11:0] bits, input int n,
                         input int div, input int cts_drop_at);
        for (int k = 0; k < n * div; k++) begin
            check($sformatf("%s line k=%0d", name, k), {31'b0, o_uart_tx}, {31'b0, bits[k / div]});
            check($sformatf("%s busy k=%0d", name, k), {31'b0, o_tx_busy}, 32'd1);
            if (k == cts_drop_at) i_uart_cts = 1'b0;
            tick();
        end
        check({name, " line after frame"}, {31'b0, o_uart_tx}, 32'd1);
        check({name, " busy after frame"}, {31'b0, o_tx_busy}, 32'd0);
    endtask

    task automatic offer(input logic [7:0] data);
        i_user_tx_data  = data;
        i_user_tx_valid = 1'b1;
        #1;
        check("ready before accept", {31'b0, o_user_tx_ready}, 32'd1);
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        i_uart_cts      = 1'b1;
        i_user_tx_valid = 1'b0;
        i_user_tx_data  = 8'h00;
        set_cfg(24'd4, 4'd8, 2'd1, 2'd0);
        tick(); tick(); tick();
        check("reset line", {31'b0, o_uart_tx}, 32'd1);
        check("reset busy", {31'b0, o_tx_busy}, 32'd0);
        check("reset ready", {31'b0, o_user_tx_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready after reset", {31'b0, o_user_tx_ready}, 32'd1);

        // 8N1 div 4, 0xA5; config scrambled after accept must not matter
        set_cfg(24'd4, 4'd8, 2'd1, 2'd0);
        offer(8'hA5);
        i_user_tx_valid = 1'b0;
        i_user_tx_data  = 8'h00;
        set_cfg(24'd7, 4'd5, 2'd2, 2'd1);
        frame("a5_8n1", 12'b1101001010, 10, 4, -1);

        set_cfg(24'd3, 4'd8, 2'd1, 2'd2);
        offer(8'hA5);
        i_user_tx_valid = 1'b0;
        frame("a5_even", 12'b10101001010, 11, 3, -1);

        set_cfg(24'd3, 4'd8, 2'd1, 2'd1);
        offer(8'hA5);
        i_user_tx_valid = 1'b0;
        frame("a5_odd", 12'b11101001010, 11, 3, -1);

        set_cfg(24'd2, 4'd5, 2'd2, 2'd0);
        offer(8'hFF);
        i_user_tx_valid = 1'b0;
        frame("ff_5n2", 12'b11111110, 8, 2, -1);

        // div 0 -> 2, width 12 -> 8, parity 3 -> none, stop 3 -> one
        set_cfg(24'd0, 4'd12, 2'd3, 2'd3);
        offer(8'h3C);
        i_user_tx_valid = 1'b0;
        frame("3c_clamp", 12'b1001111000, 10, 2, -1);

        // Back-to-back with valid held: exactly one idle cycle between frames
        set_cfg(24'd4, 4'd8, 2'd1, 2'd0);
        offer(8'h12);
        i_user_tx_data = 8'h34;
        frame("b2b_12", 12'b1000100100, 10, 4, -1);
        check("b2b ready in gap", {31'b0, o_user_tx_ready}, 32'd1);
        tick();
        i_user_tx_valid = 1'b0;
        frame("b2b_34", 12'b1001101000, 10, 4, -1);

        // CTS drops mid-frame: frame completes, next byte waits for CTS
        offer(8'h12);
        i_user_tx_data = 8'h34;
        frame("cts_12", 12'b1000100100, 10, 4, 5);
        for (int i = 0; i < 3; i++) begin
            check("cts low ready", {31'b0, o_user_tx_ready}, 32'd0);
            check("cts low line", {31'b0, o_uart_tx}, 32'd1);
            check("cts low busy", {31'b0, o_tx_busy}, 32'd0);
            tick();
        end
        i_uart_cts = 1'b1;
        #1;
        check("cts high ready", {31'b0, o_user_tx_ready}, 32'd1);
        tick();
        i_user_tx_valid = 1'b0;
        frame("cts_34", 12'b1001101000, 10, 4, -1);

        // Reset during data bit 3 aborts the frame
        offer(8'hA5);
        i_user_tx_valid = 1'b0;
        repeat (17) tick();
        check("pre-reset line d3", {31'b0, o_uart_tx}, 32'd0);
        check("pre-reset busy", {31'b0, o_tx_busy}, 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid reset line", {31'b0, o_uart_tx}, 32'd1);
            check("mid reset busy", {31'b0, o_tx_busy}, 32'd0);
            check("mid reset ready", {31'b0, o_user_tx_ready}, 32'd0);
        end
        reset = 1'b0;
        set_cfg(24'd0, 4'd12, 2'd3, 2'd3);
        offer(8'h3C);
        i_user_tx_valid = 1'b0;
        frame("post_reset_3c", 12'b1001111000, 10, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
